// File: rtl/pc_fetch_pkg.sv
// Shared core definitions for the fetch stage: instruction constants,
// next-PC select encodings, fetch FSM states and memory geometry.
package pc_fetch_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic        PC_SRC_SEQ    = 1'b0;
    localparam logic        PC_SRC_TARGET = 1'b1;
    localparam int          IMEM_DEPTH    = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_pc_next.sv
// Next-PC adder and target legality checker; purely combinational so the
// branch unit can share it.
module pc_next
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic [31:0] i_pc,
    input  logic        i_pc_src,
    input  logic [31:0] i_imm_ext,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misaligned,
    output logic        o_out_of_range,
    output logic        o_illegal
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(4 * DEPTH);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4  = i_pc + 32'd4;
    assign w_pc_target = i_pc + i_imm_ext;
    assign w_next_pc   = (i_pc_src == PC_SRC_TARGET) ? w_pc_target : w_pc_plus4;

    assign o_next_pc      = w_next_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_misaligned   = (w_next_pc[1:0] != 2'b00);
    assign o_out_of_range = (w_next_pc >= PC_LIMIT);
    assign o_illegal      = o_misaligned | o_out_of_range;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch control: drives the instruction memory address,
// gates the returned instruction, and tracks run/halt/fault state.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_src,
    input  logic [31:0]       imm_ext,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       inst_in,
    output logic [31:0]       inst,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fault_pc,
    output logic [31:0]       retired
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_retired;
    logic [31:0]  w_retired_next;
    logic [31:0]  w_retired_inc;
    logic [31:0]  r_fault_pc;
    logic [31:0]  w_fault_pc_next;

    logic [31:0]  w_target_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_misaligned;
    logic         w_out_of_range;
    logic         w_illegal;
    logic         w_zero_inst;

    pc_next #(
        .DEPTH (DEPTH)
    ) u_pc_next (
        .i_pc           (r_pc),
        .i_pc_src       (pc_src),
        .i_imm_ext      (imm_ext),
        .o_next_pc      (w_target_pc),
        .o_pc_plus4     (w_pc_plus4),
        .o_misaligned   (w_misaligned),
        .o_out_of_range (w_out_of_range),
        .o_illegal      (w_illegal)
    );

    assign w_zero_inst   = (inst_in == 32'd0);
    // Counter sticks at all-ones rather than wrapping back to zero.
    assign w_retired_inc = (r_retired == 32'hFFFF_FFFF) ? r_retired : r_retired + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_retired  <= 32'd0;
            r_fault_pc <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_retired  <= w_retired_next;
            r_fault_pc <= w_fault_pc_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_retired_next  = r_retired;
        w_fault_pc_next = r_fault_pc;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (w_zero_inst) begin
                        w_state_next = ST_HALT;
                    end else if (w_illegal) begin
                        // The branching instruction itself completed; only the target is bad.
                        w_state_next    = ST_FAULT;
                        w_fault_pc_next = w_target_pc;
                        w_retired_next  = w_retired_inc;
                    end else begin
                        w_pc_next      = w_target_pc;
                        w_retired_next = w_retired_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    assign address  = r_pc[ADDR_W+1:2];
    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign valid    = (r_state == ST_RUN) && !stall && !w_zero_inst;
    assign inst     = valid ? inst_in : NOP_INST;
    assign halted   = (r_state == ST_HALT);
    assign fault    = (r_state == ST_FAULT);
    assign fault_pc = r_fault_pc;
    assign retired  = r_retired;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, branches, stall, halt,
// fault on misaligned/out-of-range targets, and reset recovery.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic [4:0]  address;
    logic [31:0] inst_in;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81B3;

    pc_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .pc_src   (pc_src),
        .imm_ext  (imm_ext),
        .address  (address),
        .inst_in  (inst_in),
        .inst     (inst),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .valid    (valid),
        .halted   (halted),
        .fault    (fault),
        .fault_pc (fault_pc),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        pc_src  = 1'b0;
        imm_ext = 32'd0;
        inst_in = ADD;
        tick();
        reset = 1'b0;
        settle();

        // Reset state
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", {27'd0, address}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd1);
        chk("rst_inst", inst, ADD);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        $display("reset: pc=%0d retired=%0d", pc, retired);

        // Sequential fetch 0 -> 4 -> 8 -> 12
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", pc, 32'(4 * i));
            chk("seq_addr", {27'd0, address}, 32'(i));
            $display("seq step %0d: pc=%0d address=%0d retired=%0d", i, pc, address, retired);
        end
        chk("seq_retired", retired, 32'd3);
        chk("seq_pc_plus4", pc_plus4, 32'd16);

        tick();
        tick();
        chk("pre_stall_pc", pc, 32'd20);
        chk("pre_stall_retired", retired, 32'd5);

        // Stall for 2 cycles at pc=20; second cycle also presents a zero word
        stall = 1'b1;
        settle();
        chk("stall_valid", {31'd0, valid}, 32'd0);
        chk("stall_inst", inst, NOP);
        tick();
        inst_in = 32'd0;
        settle();
        chk("stall_zero_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("stall_pc", pc, 32'd20);
        chk("stall_retired", retired, 32'd5);
        chk("stall_no_halt", {31'd0, halted}, 32'd0);
        $display("stall: pc=%0d retired=%0d halted=%0d", pc, retired, halted);
        stall   = 1'b0;
        inst_in = ADD;

        // Branches: 20 -> 52 -> 68 -> 64 -> 52
        pc_src  = 1'b1;
        imm_ext = 32'd32;
        tick();
        chk("br_pc_52", pc, 32'd52);
        imm_ext = 32'd16;
        tick();
        chk("br_pc_68", pc, 32'd68);
        imm_ext = 32'hFFFF_FFFC;
        tick();
        chk("br_pc_64", pc, 32'd64);
        imm_ext = 32'hFFFF_FFF4;
        tick();
        chk("br_pc_back52", pc, 32'd52);
        chk("br_retired", retired, 32'd9);
        $display("branch: pc=%0d retired=%0d", pc, retired);

        // Halt at pc=120
        imm_ext = 32'd68;
        tick();
        chk("pre_halt_pc", pc, 32'd120);
        inst_in = 32'd0;
        pc_src  = 1'b0;
        settle();
        chk("halt_zero_valid", {31'd0, valid}, 32'd0);
        chk("halt_zero_inst", inst, NOP);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        tick();
        chk("halted", {31'd0, halted}, 32'd1);
        inst_in = ADD;
        for (int i = 0; i < 5; i++) begin
            pc_src  = 1'($urandom_range(0, 1));
            imm_ext = 32'($urandom_range(0, 15)) << 2;
            stall   = 1'($urandom_range(0, 1));
            tick();
            chk("halt_pc", pc, 32'd120);
            chk("halt_retired", retired, 32'd10);
            chk("halt_sticky", {31'd0, halted}, 32'd1);
            chk("halt_valid", {31'd0, valid}, 32'd0);
            $display("halt cycle %0d: pc=%0d retired=%0d halted=%0d", i, pc, retired, halted);
        end
        stall  = 1'b0;
        pc_src = 1'b0;

        // Reset out of HALT
        do_reset();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_pc", pc, 32'd0);

        // Misaligned target from pc=8
        tick();
        tick();
        chk("pre_fault_pc", pc, 32'd8);
        pc_src  = 1'b1;
        imm_ext = 32'd6;
        tick();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_fault_pc", fault_pc, 32'd14);
        chk("mis_pc", pc, 32'd8);
        chk("mis_retired", retired, 32'd3);
        chk("mis_valid", {31'd0, valid}, 32'd0);
        chk("mis_halted", {31'd0, halted}, 32'd0);
        $display("misaligned: fault=%0d fault_pc=%0d pc=%0d retired=%0d", fault, fault_pc, pc, retired);
        imm_ext = 32'd4;
        tick();
        chk("fault_sticky_pc", pc, 32'd8);

        // Reset asserted in FAULT: outputs show old state until the edge
        reset = 1'b1;
        settle();
        chk("rst_pre_edge_fault", {31'd0, fault}, 32'd1);
        tick();
        reset = 1'b0;
        settle();
        chk("rst3_fault", {31'd0, fault}, 32'd0);
        chk("rst3_pc", pc, 32'd0);
        chk("rst3_retired", retired, 32'd0);
        chk("rst3_fault_pc", fault_pc, 32'd0);
        $display("reset from fault: fault=%0d pc=%0d retired=%0d fault_pc=%0d", fault, pc, retired, fault_pc);

        // Last word is a legal target; stepping off it faults
        pc_src  = 1'b1;
        imm_ext = 32'd124;
        tick();
        chk("last_word_pc", pc, 32'd124);
        chk("last_word_fault", {31'd0, fault}, 32'd0);
        chk("last_word_addr", {27'd0, address}, 32'd31);
        pc_src = 1'b0;
        tick();
        chk("off_end_fault", {31'd0, fault}, 32'd1);
        chk("off_end_fault_pc", fault_pc, 32'd128);
        chk("off_end_pc", pc, 32'd124);
        chk("off_end_retired", retired, 32'd2);
        $display("off end: fault=%0d fault_pc=%0d pc=%0d", fault, fault_pc, pc);

        // Backward wrap below zero is out of range, not aliased
        do_reset();
        pc_src  = 1'b1;
        imm_ext = 32'hFFFF_FFFC;
        tick();
        chk("neg_fault", {31'd0, fault}, 32'd1);
        chk("neg_fault_pc", fault_pc, 32'hFFFF_FFFC);
        chk("neg_pc", pc, 32'd0);
        $display("negative target: fault=%0d fault_pc=%h", fault, fault_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-control stage for the single-cycle RISC-V core. It sits directly upstream of the instruction memory and drives the memory's 5-bit word address from its PC register. It forwards the returned 32-bit instruction to decode and selects the next PC: sequential, or branch/jump target. It also detects end-of-program (all-zero word), halts, and flags illegal or misaligned PC targets.

## Interface
- `DEPTH`, 32: instruction memory depth in words. `ADDR_W` = log2(`DEPTH`) = 5.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset. Must be word-aligned and inside memory.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and counters this cycle.
- `pc_src`  in  1  0 = PC+4, 1 = PC+`imm_ext` (branch taken / jal).
- `imm_ext`  in  32  sign-extended branch/jump offset, in bytes.
- `address`  out  `ADDR_W`  word address to instruction memory; equals `pc[ADDR_W+1:2]`.
- `inst_in`  in  32  instruction returned by the instruction memory (combinational).
- `inst`  out  32  instruction to decode; equals `inst_in` when `valid`, else 32'h0000_0013 (nop).
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc`+4, for jal/jalr link.
- `valid`  out  1  the current instruction executes this cycle.
- `halted`  out  1  state is HALT.
- `fault`  out  1  state is FAULT.
- `fault_pc`  out  32  offending target captured on entry to FAULT.
- `retired`  out  32  count of instructions executed since reset.

## Operation
- FSM states: RUN, HALT, FAULT. Reset: state=RUN, `pc`=`RESET_PC`, `retired`=0, `fault_pc`=0.
- Reset values of outputs: `halted`=0, `fault`=0, `valid`=1 unless `stall` is asserted, `address`=`RESET_PC[6:2]`.
- `valid` = (state==RUN) && !`stall` && (`inst_in` != 0).
- `next_pc` = `pc_src` ? `pc`+`imm_ext` : `pc`+4. Arithmetic is 32-bit modulo 2^32; no carry out.
- RUN, `stall`=1: no state change. Halt and fault checks are suppressed.
- RUN, `inst_in`==0: go to HALT. `pc` and `retired` hold. The zero word is not counted.
- RUN, `next_pc[1:0]`!=0, or `next_pc` >= 4*`DEPTH`: go to FAULT. `fault_pc`=`next_pc`. `pc` holds. `retired` increments, because the faulting instruction itself executed.
- RUN, otherwise: `pc`=`next_pc`, `retired`+1.
- HALT and FAULT are sticky. They are left only by `reset`. `pc_src`, `imm_ext` and `stall` are ignored in these states.
- Priority, highest first: `reset` > `stall` > zero-instruction halt > fault check > advance.
- A target of exactly 4*`DEPTH`-4 is legal. A sequential step off the last word faults; it does not wrap.
- `retired` saturates at 32'hFFFF_FFFF.

## Timing
- `address` is combinational from the `pc` register. `inst_in` arrives in the same cycle. `next_pc` is combinational. Fetch-to-execute latency is therefore 0 cycles, and the PC updates on the following rising edge.
- State, `pc`, `retired` and `fault_pc` update on the edge that samples the inputs. `halted` and `fault` assert in the cycle after the triggering instruction.
- Reset asserted mid-operation, including in HALT or FAULT, takes effect at the next edge. In that edge's cycle the outputs still show pre-reset state.

## Structure
- Shared core package holds: `NOP_INST` = 32'h0000_0013, `PC_SRC_SEQ`/`PC_SRC_TARGET` encodings, the fetch-state enum, and `IMEM_DEPTH` = 32.
- One sub-module, `pc_next`: combinational `next_pc` and `pc_plus4` adder plus the alignment/range checker, so the decode/branch unit can reuse it.
- The FSM, PC register and counters are top-level.

## Test plan
- Reset, then 3 cycles with `pc_src`=0 and nonzero `inst_in` -> `pc` sequence 0, 4, 8, 12; `address` 0, 1, 2, 3; `retired`=3.
- At `pc`=52: `pc_src`=1, `imm_ext`=16 -> `pc`=68. At `pc`=64: `imm_ext`=-12 (32'hFFFF_FFF4) -> `pc`=52.
- `stall`=1 for 2 cycles at `pc`=20 -> `pc` stays 20, `retired` unchanged, `valid`=0, `inst`=32'h0000_0013.
- `inst_in`=0 at `pc`=120 -> next cycle `halted`=1; `pc` stays 120 for 5 further cycles with random `pc_src`; `retired` frozen.
- At `pc`=8: `imm_ext`=6 -> `fault`=1, `fault_pc`=14, `pc`=8. Separately, at `pc`=124 with `pc_src`=0 -> `fault`=1, `fault_pc`=128.
- `reset` pulsed while in FAULT -> next cycle state RUN, `pc`=0, `retired`=0, `fault_pc`=0, `fault`=0.
